// File: rtl/time_param_programmer.sv
// Front-panel editor for the three interval registers: debounces four buttons, runs the
// edit session, then writes the committed value with a setup/pulse/hold Reprogram strobe.
module time_param_programmer #(
    parameter int unsigned DEB_CYCLES     = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned DEF_BASE       = 6,
    parameter int unsigned DEF_EXT        = 3,
    parameter int unsigned DEF_YEL        = 2
) (
    input  logic       clk,
    input  logic       Sync_Reset,
    input  logic       Btn_Up,
    input  logic       Btn_Down,
    input  logic       Btn_Next,
    input  logic       Btn_Commit,
    output logic [1:0] Selector,
    output logic [3:0] Time_Value,
    output logic       Reprogram,
    output logic       Edit_Active,
    output logic       Busy
);

    localparam int unsigned NBTN     = 4;
    localparam int unsigned B_UP     = 0;
    localparam int unsigned B_DOWN   = 1;
    localparam int unsigned B_NEXT   = 2;
    localparam int unsigned B_COMMIT = 3;
    localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PH_MAX0  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int unsigned PH_MAX   = (PH_MAX0 > HOLD_CYCLES) ? PH_MAX0 : HOLD_CYCLES;
    localparam int unsigned PH_W     = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_EDIT, S_DRIVE, S_PULSE, S_HOLD} state_t;

    logic [NBTN-1:0]  btn_raw, sync1, sync2, deb, deb_q, evt;
    logic [DEB_W-1:0] deb_cnt [NBTN];

    assign btn_raw = {Btn_Commit, Btn_Next, Btn_Down, Btn_Up};
    assign evt     = deb & ~deb_q;

    // Synchronise and debounce: the level flips only after DEB_CYCLES differing samples
    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < NBTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    state_t          state, state_nxt;
    logic [1:0]      sel, sel_nxt;
    logic [3:0]      edit [3];
    logic [3:0]      edit_nxt [3];
    logic [3:0]      shadow [3];
    logic [3:0]      shadow_nxt [3];
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [PH_W-1:0] ph_cnt, ph_cnt_nxt;
    logic [1:0]      selector_nxt;
    logic [3:0]      time_value_nxt;
    logic            reprogram_nxt, edit_active_nxt, busy_nxt;
    logic            up_only, down_only;

    assign up_only   = evt[B_UP] & ~evt[B_DOWN];
    assign down_only = evt[B_DOWN] & ~evt[B_UP];

    always_ff @(posedge clk) begin
        if (Sync_Reset) begin
            state       <= S_IDLE;
            sel         <= '0;
            edit[0]     <= 4'(DEF_BASE);
            edit[1]     <= 4'(DEF_EXT);
            edit[2]     <= 4'(DEF_YEL);
            shadow[0]   <= 4'(DEF_BASE);
            shadow[1]   <= 4'(DEF_EXT);
            shadow[2]   <= 4'(DEF_YEL);
            to_cnt      <= '0;
            ph_cnt      <= '0;
            Selector    <= '0;
            Time_Value  <= 4'(DEF_BASE);
            Reprogram   <= 1'b0;
            Edit_Active <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            edit        <= edit_nxt;
            shadow      <= shadow_nxt;
            to_cnt      <= to_cnt_nxt;
            ph_cnt      <= ph_cnt_nxt;
            Selector    <= selector_nxt;
            Time_Value  <= time_value_nxt;
            Reprogram   <= reprogram_nxt;
            Edit_Active <= edit_active_nxt;
            Busy        <= busy_nxt;
        end
    end

    // Next state, edit/shadow updates, and the registered output values derived from them
    always_comb begin
        state_nxt  = state;
        sel_nxt    = sel;
        edit_nxt   = edit;
        shadow_nxt = shadow;
        to_cnt_nxt = to_cnt;
        ph_cnt_nxt = ph_cnt;

        case (state)
            S_IDLE: begin
                if (evt[B_NEXT]) begin
                    state_nxt  = S_EDIT;
                    sel_nxt    = 2'd0;
                    to_cnt_nxt = '0;
                end
            end
            S_EDIT: begin
                if (|evt) begin
                    to_cnt_nxt = '0;
                end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    edit_nxt   = shadow;
                    state_nxt  = S_IDLE;
                    to_cnt_nxt = '0;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end

                if (evt[B_COMMIT]) begin
                    shadow_nxt[sel] = edit[sel];
                    state_nxt       = S_DRIVE;
                    ph_cnt_nxt      = '0;
                end else if (evt[B_NEXT]) begin
                    sel_nxt = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                end else if (up_only) begin
                    if (edit[sel] != 4'd15) edit_nxt[sel] = edit[sel] + 4'd1;
                end else if (down_only) begin
                    if (edit[sel] > 4'd1) edit_nxt[sel] = edit[sel] - 4'd1;
                end
            end
            S_DRIVE: begin
                if (ph_cnt == PH_W'(SETUP_CYCLES - 1)) begin
                    state_nxt  = S_PULSE;
                    ph_cnt_nxt = '0;
                end else begin
                    ph_cnt_nxt = ph_cnt + PH_W'(1);
                end
            end
            S_PULSE: begin
                if (ph_cnt == PH_W'(PULSE_CYCLES - 1)) begin
                    state_nxt  = S_HOLD;
                    ph_cnt_nxt = '0;
                end else begin
                    ph_cnt_nxt = ph_cnt + PH_W'(1);
                end
            end
            S_HOLD: begin
                if (ph_cnt == PH_W'(HOLD_CYCLES - 1)) begin
                    state_nxt  = S_EDIT;
                    ph_cnt_nxt = '0;
                    to_cnt_nxt = '0;
                end else begin
                    ph_cnt_nxt = ph_cnt + PH_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // sel and edit are frozen while busy, so the written pair stays stable
        selector_nxt   = sel_nxt;
        time_value_nxt = edit_nxt[sel_nxt];
        if (state_nxt == S_IDLE) begin
            selector_nxt   = 2'd0;
            time_value_nxt = shadow_nxt[0];
        end
        reprogram_nxt   = (state_nxt == S_PULSE);
        edit_active_nxt = (state_nxt == S_EDIT);
        busy_nxt        = (state_nxt == S_DRIVE) || (state_nxt == S_PULSE) || (state_nxt == S_HOLD);
    end

endmodule

// File: tb/tb_time_param_programmer.sv
// Directed bench for time_param_programmer: table of button steps with expected panel state,
// plus hand sequences for commit timing, reset mid-pulse and presses during HOLD.
module tb_time_param_programmer;

    logic       clk = 1'b0;
    logic       Sync_Reset;
    logic       Btn_Up, Btn_Down, Btn_Next, Btn_Commit;
    logic [1:0] Selector;
    logic [3:0] Time_Value;
    logic       Reprogram, Edit_Active, Busy;

    time_param_programmer #(
        .DEB_CYCLES(4), .TIMEOUT_CYCLES(50),
        .SETUP_CYCLES(4), .PULSE_CYCLES(4), .HOLD_CYCLES(4),
        .DEF_BASE(6), .DEF_EXT(3), .DEF_YEL(2)
    ) dut (
        .clk(clk), .Sync_Reset(Sync_Reset),
        .Btn_Up(Btn_Up), .Btn_Down(Btn_Down), .Btn_Next(Btn_Next), .Btn_Commit(Btn_Commit),
        .Selector(Selector), .Time_Value(Time_Value), .Reprogram(Reprogram),
        .Edit_Active(Edit_Active), .Busy(Busy)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] M_NONE = 4'b0000;
    localparam logic [3:0] M_UP   = 4'b0001;
    localparam logic [3:0] M_DN   = 4'b0010;
    localparam logic [3:0] M_NX   = 4'b0100;
    localparam logic [3:0] M_CM   = 4'b1000;

    typedef struct {
        logic [3:0]  btn;
        logic        bounce;
        int unsigned idle;
        logic [1:0]  sel;
        logic [3:0]  tv;
        logic        edit;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add_vec(input logic [3:0] btn, input logic bounce, input int unsigned idle,
                                    input logic [1:0] sel, input logic [3:0] tv, input logic edit);
        vec_t v;
        v.btn = btn; v.bounce = bounce; v.idle = idle; v.sel = sel; v.tv = tv; v.edit = edit;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m);
        {Btn_Commit, Btn_Next, Btn_Down, Btn_Up} = m;
    endtask

    task automatic press(input logic [3:0] m);
        drive(m);
        repeat (10) @(negedge clk);
        drive(M_NONE);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        Sync_Reset = 1'b1;
        drive(M_NONE);
        repeat (3) @(negedge clk);
        Sync_Reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].bounce) begin
                repeat (6) begin
                    drive(vecs[i].btn);
                    repeat (2) @(negedge clk);
                    drive(M_NONE);
                    repeat (2) @(negedge clk);
                end
            end
            if (vecs[i].btn != M_NONE) press(vecs[i].btn);
            repeat (vecs[i].idle) @(negedge clk);
            check($sformatf("v%0d_sel", i), 32'(Selector), 32'(vecs[i].sel));
            check($sformatf("v%0d_tv", i), 32'(Time_Value), 32'(vecs[i].tv));
            check($sformatf("v%0d_edit", i), 32'(Edit_Active), 32'(vecs[i].edit));
            check($sformatf("v%0d_busy", i), 32'(Busy), 32'd0);
            check($sformatf("v%0d_rep", i), 32'(Reprogram), 32'd0);
        end
    endtask

    // Poll until Busy rises; an expired bound is recorded as a failed comparison
    task automatic wait_busy(input string name);
        int w = 0;
        while (!Busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        check(name, 32'(Busy), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int rep_cnt;
        int w;

        // Reset state, bounce, navigation, saturating decrement
        add_vec(M_NONE, 1'b0, 20, 2'd0, 4'd6, 1'b0);
        add_vec(M_NX,   1'b0, 0,  2'd0, 4'd6, 1'b1);
        add_vec(M_UP,   1'b1, 0,  2'd0, 4'd7, 1'b1);
        add_vec(M_NX,   1'b0, 0,  2'd1, 4'd3, 1'b1);
        add_vec(M_NX,   1'b0, 0,  2'd2, 4'd2, 1'b1);
        add_vec(M_DN,   1'b0, 0,  2'd2, 4'd1, 1'b1);
        add_vec(M_DN,   1'b0, 0,  2'd2, 4'd1, 1'b1);
        add_vec(M_DN,   1'b0, 0,  2'd2, 4'd1, 1'b1);
        // Wrap to sel 00, saturating increment, timeout discard
        add_vec(M_NX,   1'b0, 0,  2'd0, 4'd7, 1'b1);
        for (int i = 0; i < 12; i++)
            add_vec(M_UP, 1'b0, 0, 2'd0, ((8 + i) > 15) ? 4'd15 : 4'(8 + i), 1'b1);
        add_vec(M_NONE, 1'b0, 50, 2'd0, 4'd6, 1'b0);
        // Simultaneous presses
        add_vec(M_NX,        1'b0, 0,  2'd0, 4'd6, 1'b1);
        add_vec(M_UP | M_DN, 1'b0, 0,  2'd0, 4'd6, 1'b1);
        add_vec(M_NX,        1'b0, 0,  2'd1, 4'd3, 1'b1);
        add_vec(M_CM | M_NX, 1'b0, 10, 2'd1, 4'd3, 1'b1);

        do_reset();
        check("rst_sel", 32'(Selector), 32'd0);
        check("rst_tv", 32'(Time_Value), 32'd6);
        check("rst_rep", 32'(Reprogram), 32'd0);
        check("rst_edit", 32'(Edit_Active), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);

        run_rows(0, 7);

        // Commit timing: 12 busy cycles, Reprogram on cycles 5..8, outputs frozen
        drive(M_CM);
        wait_busy("commit_busy_rise");
        for (int k = 1; k <= 14; k++) begin
            check($sformatf("ct%0d_busy", k), 32'(Busy), 32'(k <= 12));
            check($sformatf("ct%0d_rep", k), 32'(Reprogram), 32'(k >= 5 && k <= 8));
            if (k <= 12) begin
                check($sformatf("ct%0d_sel", k), 32'(Selector), 32'd2);
                check($sformatf("ct%0d_tv", k), 32'(Time_Value), 32'd1);
            end
            if (k == 3) drive(M_NONE);
            @(negedge clk);
        end
        check("ct_back_edit", 32'(Edit_Active), 32'd1);

        run_rows(8, vecs.size() - 1);

        // Reset two cycles into PULSE aborts the write and restores defaults
        do_reset();
        press(M_NX);
        press(M_UP);
        check("r6_tv_pre", 32'(Time_Value), 32'd7);
        drive(M_CM);
        w = 0;
        while (!Reprogram && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("r6_pulse_seen", 32'(Reprogram), 32'd1);
        @(negedge clk);
        Sync_Reset = 1'b1;
        drive(M_NONE);
        @(negedge clk);
        check("r6_rep", 32'(Reprogram), 32'd0);
        check("r6_busy", 32'(Busy), 32'd0);
        check("r6_sel", 32'(Selector), 32'd0);
        check("r6_tv", 32'(Time_Value), 32'd6);
        check("r6_edit", 32'(Edit_Active), 32'd0);
        Sync_Reset = 1'b0;
        repeat (10) @(negedge clk);
        press(M_NX);
        check("r6_edit_tv", 32'(Time_Value), 32'd6);
        check("r6_edit_act", 32'(Edit_Active), 32'd1);

        // Up pressed so its event lands in HOLD: dropped, single pulse
        do_reset();
        press(M_NX);
        drive(M_CM);
        wait_busy("h_busy_rise");
        rep_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            if (Reprogram) rep_cnt++;
            if (k == 3) Btn_Commit = 1'b0;
            if (k == 5) Btn_Up = 1'b1;
            if (k == 12) Btn_Up = 1'b0;
            @(negedge clk);
        end
        check("h_rep_cycles", 32'(rep_cnt), 32'd4);
        repeat (15) @(negedge clk);
        check("h_tv", 32'(Time_Value), 32'd6);
        check("h_sel", 32'(Selector), 32'd0);
        check("h_edit", 32'(Edit_Active), 32'd1);
        check("h_busy", 32'(Busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
